// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing for the data-memory arbiter: FSM state encoding,
// counter widths and default parameter values.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STEAL = 1'b1
  } arb_state_e;

  localparam int WAIT_LIMIT_DEF = 8;
  localparam int MAX_BURST_DEF  = 4;

  localparam int WAIT_W  = 8;   // holds WAIT_LIMIT-1 up to 254
  localparam int BURST_W = 4;   // holds MAX_BURST-1 up to 14
  localparam int STAT_W  = 16;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle around the arbiter: core load/store path, dump read path and the
// datamem port. The slave modport is the arbiter's view.
interface dmem_arbiter_if;

  logic        core_valid;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;

  logic        dump_req;
  logic [31:0] dump_addr;
  logic        dump_gnt;
  logic [31:0] dump_rdata;
  logic        dump_rvalid;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  core_valid, core_we, core_addr, core_wdata,
    input  dump_req, dump_addr,
    input  mem_rdata,
    output core_rdata, core_stall,
    output dump_gnt, dump_rdata, dump_rvalid,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_valid, core_we, core_addr, core_wdata,
    output dump_req, dump_addr,
    output mem_rdata,
    input  core_rdata, core_stall,
    input  dump_gnt, dump_rdata, dump_rvalid,
    input  mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_arb_stats.sv
// Saturating stall/dump-grant counters; the module only exists when
// DMEM_ARB_STATS_EN is defined.
`ifdef DMEM_ARB_STATS_EN
module dmem_arb_stats
  import dmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              syncreset,
  input  logic              stall,
  input  logic              gnt,
  output logic [STAT_W-1:0] stat_stall,
  output logic [STAT_W-1:0] stat_dump
);

  always_ff @(posedge clk) begin
    if (syncreset) begin
      stat_stall <= '0;
      stat_dump  <= '0;
    end else begin
      if (stall && (stat_stall != '1)) stat_stall <= stat_stall + 1'b1;
      if (gnt && (stat_dump != '1))    stat_dump  <= stat_dump + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core has priority, dump engine takes idle slots and
// steals bounded bursts after waiting. Optional counters: DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              syncreset,
  dmem_arbiter_if.slave     bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stall,
  output logic [STAT_W-1:0] stat_dump
`endif
);

  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(WAIT_LIMIT - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  arb_state_e         state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic               dump_sel;
  logic               gnt;
  logic               stall;
  logic [31:0]        dump_rdata_q;
  logic               dump_rvalid_q;

  // Grant, stall and port select are Mealy; held low while reset is asserted.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dump_sel = 1'b0;
    gnt      = 1'b0;
    stall    = 1'b0;
    if (!syncreset) begin
      unique case (state)
        IDLE: begin
          if (bus.dump_req && !bus.core_valid) begin
            dump_sel = 1'b1;
            gnt      = 1'b1;
          end
        end
        STEAL: begin
          // Dropping dump_req hands the port straight back to the core.
          if (bus.dump_req) begin
            dump_sel = 1'b1;
            gnt      = 1'b1;
            stall    = bus.core_valid;
          end
        end
      endcase
    end
  end

  assign bus.mem_we     = !dump_sel && bus.core_valid && bus.core_we;
  assign bus.mem_addr   = dump_sel ? bus.dump_addr : bus.core_addr;
  assign bus.mem_wdata  = bus.core_wdata;
  assign bus.core_rdata = dump_sel ? 32'h0 : bus.mem_rdata;
  assign bus.core_stall = stall;
  assign bus.dump_gnt   = gnt;
  assign bus.dump_rdata  = dump_rdata_q;
  assign bus.dump_rvalid = dump_rvalid_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (syncreset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      burst_cnt     <= '0;
      dump_rvalid_q <= 1'b0;
      dump_rdata_q  <= '0;
    end else begin
      dump_rvalid_q <= gnt;
      if (gnt) dump_rdata_q <= bus.mem_rdata;

      unique case (state)
        IDLE: begin
          if (bus.dump_req && bus.core_valid) begin
            if (wait_cnt == WAIT_LAST) begin
              state    <= STEAL;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else begin
            wait_cnt <= '0;
          end
        end
        STEAL: begin
          if (!bus.dump_req || (burst_cnt == BURST_LAST)) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats u_stats (
    .clk        (clk),
    .syncreset  (syncreset),
    .stall      (stall),
    .gnt        (gnt),
    .stat_stall (stat_stall),
    .stat_dump  (stat_dump)
  );
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter and core-stall controller for the single-cycle RISC-V core. It shares `datamem` between the core's load/store path and a debug dump engine that streams memory words out over the UART. The core has priority. The dump engine gets idle slots, and after a bounded wait it may steal cycles by stalling the PC. The block sits between `alu`/`regfile` outputs, `datamem`, and the `pc` load/hold control in `topmod`.

## Interface
Parameters:
- `WAIT_LIMIT`, 8: consecutive denied dump-request cycles before a steal is forced (1..255).
- `MAX_BURST`, 4: maximum consecutive stolen cycles per steal (1..15).

Ports:
- `clk` in 1: core clock; all state updates on its rising edge.
- `syncreset` in 1: synchronous, active-high reset.
- `core_valid` in 1: the current instruction accesses memory (load or store).
- `core_we` in 1: the current instruction is a store (`MemWrite`).
- `core_addr` in 32: byte address (`aluresult`).
- `core_wdata` in 32: store data (`RD2`).
- `core_rdata` out 32: load data to the result mux.
- `core_stall` out 1: hold the PC and suppress register and memory writes this cycle.
- `dump_req` in 1: dump engine requests a read.
- `dump_addr` in 32: dump read address.
- `dump_gnt` out 1: dump read performed this cycle.
- `dump_rdata` out 32: registered read data.
- `dump_rvalid` out 1: `dump_rdata` is valid.
- `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32: drive `datamem`.
- `mem_rdata` in 32: combinational `datamem` read data.

## Operation
- States:
  - `IDLE`: core owns the port.
  - `STEAL`: dump owns the port, core stalled.
- `IDLE` behaviour:
  - Memory port muxed to the core; `mem_we = core_valid & core_we`.
  - If `dump_req & ~core_valid`: `dump_gnt=1`, port muxed to `dump_addr`, `mem_we=0`, no stall (free slot).
  - `wait_cnt` increments on `dump_req & core_valid`.
  - `wait_cnt` clears on any grant or when `dump_req=0`.
  - Transition to `STEAL` when `wait_cnt == WAIT_LIMIT-1` and `dump_req & core_valid` hold in the same cycle. `dump_gnt` stays 0 on that cycle and the core is served.
- `STEAL` behaviour:
  - `dump_gnt = dump_req`, port muxed to dump, `mem_we=0`.
  - `core_stall = core_valid` (a non-memory instruction proceeds unstalled).
  - `burst_cnt` increments per grant.
  - Return to `IDLE` with `wait_cnt=0` and `burst_cnt=0` when `burst_cnt == MAX_BURST-1` on a granted cycle, or when `dump_req=0`.
- `core_rdata = mem_rdata` whenever the core owns the port, else 0.
- `dump_rdata` is loaded from `mem_rdata` on every `dump_gnt`.
- `dump_rvalid` is `dump_gnt` delayed one cycle.
- Top-level duty: `topmod` gates `RegWrite` and `pcload` with `~core_stall`, so a stalled load or store re-executes cleanly next cycle.
- Address bits are passed through unchanged; no alignment checks.

## Timing
- Grant, stall and mux select are Mealy outputs (same cycle as the inputs). `dump_rvalid`/`dump_rdata` have 1-cycle latency.
- Worst-case dump wait is `WAIT_LIMIT` cycles. Worst-case core stall is `MAX_BURST` consecutive cycles.
- After a steal the core is guaranteed at least `WAIT_LIMIT` unstalled cycles before the next steal.
- Reset values:
  - State `IDLE`, `wait_cnt=0`, `burst_cnt=0`.
  - `dump_rvalid=0`, `dump_rdata=0`, `core_stall=0`, `dump_gnt=0`.
- Reset mid-steal: next cycle is `IDLE`, no stall, and the pending `dump_rvalid` is dropped.
- `dump_req` deasserted mid-burst: exit to `IDLE` that cycle; `core_stall=0` that cycle.

## Configuration
- `DMEM_ARB_STATS_EN` defined: adds outputs `stat_stall` (16-bit) and `stat_dump` (16-bit).
  - `stat_stall` counts `core_stall` cycles; `stat_dump` counts `dump_gnt` cycles.
  - Both saturate at 16'hFFFF and clear on `syncreset`.
- `DMEM_ARB_STATS_EN` undefined: the ports and counters are absent; arbitration behaviour is identical.

## Structure
- `dmem_arb_pkg`: state encoding (`IDLE=1'b0`, `STEAL=1'b1`), counter widths, and defaults for `WAIT_LIMIT`/`MAX_BURST`.
- Sub-module `dmem_arb_stats`: the two saturating counters, instantiated only under `DMEM_ARB_STATS_EN`.

## Test plan
- No core traffic, `dump_req=1`, `dump_addr=0x10` holding `0xDEADBEEF`: `dump_gnt=1` same cycle, `dump_rvalid=1` with `dump_rdata=0xDEADBEEF` next cycle, `core_stall=0`.
- Store to `0x20` of `0x1234` with `dump_req=0`: `mem_we=1`, `mem_addr=0x20`; `dump_gnt=0`.
- `core_valid=1` continuously, `dump_req=1`, `WAIT_LIMIT=8`, `MAX_BURST=4`:
  - 8 denied cycles.
  - Then exactly 4 cycles with `core_stall=1` and `dump_gnt=1`.
  - Then 8 more denied cycles before the next steal.
- `dump_req` drops after 2 stolen cycles: `core_stall=0` and state `IDLE` that cycle.
- `syncreset` during `STEAL`: next cycle `core_stall=0`, `dump_rvalid=0`, `wait_cnt` restarts from 0.
- With `DMEM_ARB_STATS_EN` defined: after the steal scenario, `stat_stall=4` and `stat_dump=4`. Forcing 70000 stall cycles gives `stat_stall=0xFFFF`.
